// File: rtl/profiler_pkg.sv
// profiler_pkg: shared types for the profiler trigger path.
// Tag layout, tag types and kernel tracking states.
package profiler_pkg;

  localparam int print_stat_tag_width_gp = 32;

  typedef enum logic [1:0] {
    generic0     = 2'b00,
    generic1     = 2'b01,
    kernel_start = 2'b10,
    kernel_end   = 2'b11
  } print_stat_type_e;

  typedef struct packed {
    print_stat_type_e tag_type;
    logic [29:0]      payload;
  } print_stat_tag_s;

  typedef enum logic {
    KS_IDLE   = 1'b0,
    KS_ACTIVE = 1'b1
  } kernel_state_e;

endpackage

// File: rtl/profiler_trigger_ctrl_if.sv
// profiler_trigger_ctrl_if: print-stat request handshake.
// master drives the request, slave returns ready.
interface profiler_trigger_ctrl_if;
  import profiler_pkg::*;

  logic                               req_v;
  logic [print_stat_tag_width_gp-1:0] req_tag;
  logic                               req_ready;

  modport master (
    output req_v,
    output req_tag,
    input  req_ready
  );

  modport slave (
    input  req_v,
    input  req_tag,
    output req_ready
  );

endinterface

// File: rtl/profiler_tag_fifo.sv
// profiler_tag_fifo: 1r1w tag queue, v/ready in, v/yumi out.
// Ready depends only on occupancy, never on a same-cycle pop.
module profiler_tag_fifo
  import profiler_pkg::*;
#(
  parameter int els_p   = 4,
  parameter int width_p = print_stat_tag_width_gp
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int PW = $clog2(els_p);
  localparam int CW = $clog2(els_p + 1);
  localparam logic [PW-1:0] LAST = PW'(els_p - 1);
  localparam logic [CW-1:0] FULL = CW'(els_p);

  logic [width_p-1:0] mem_q [els_p];
  logic [PW-1:0]      wr_q, wr_d;
  logic [PW-1:0]      rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               push, pop;

  assign ready_o = (cnt_q != FULL);
  assign v_o     = (cnt_q != '0);
  assign data_o  = mem_q[rd_q];
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;

  // Pointer wrap and occupancy bookkeeping.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
    if (pop)  rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointers; reset flushes the queue.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < els_p; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push) mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/profiler_trigger_ctrl.sv
// profiler_trigger_ctrl: queues, throttles and broadcasts print-stat
// tags; owns the global counter, kernel tracking and sample strobe.
module profiler_trigger_ctrl
  import profiler_pkg::*;
#(
  parameter int fifo_els_p = 4,
  parameter int min_gap_p  = 4,
  parameter int period_p   = 250
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  profiler_trigger_ctrl_if.slave req,
  output logic [31:0]           global_ctr_o,
  output logic                  print_stat_v_o,
  output logic [31:0]           print_stat_tag_o,
  output logic                  kernel_active_o,
  output logic [31:0]           kernel_ctr_o,
  output logic                  period_v_o
);

  localparam int TW = print_stat_tag_width_gp;
  localparam int GW = $clog2(min_gap_p + 1);
  localparam int PW = $clog2(period_p);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(min_gap_p - 1);
  localparam logic [PW-1:0] PER_LAST   = PW'(period_p - 1);

  logic            done_q, done_d;
  logic [31:0]     gctr_q, gctr_d;
  logic            psv_q, psv_d;
  print_stat_tag_s tag_q, tag_d;
  logic [GW-1:0]   gap_q, gap_d;
  kernel_state_e   st_q, st_d;
  logic [31:0]     kctr_q, kctr_d;
  logic [31:0]     kctr_inc;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic            pv_q, pv_d;

  logic            fifo_ready, fifo_v;
  logic [TW-1:0]   fifo_data;
  print_stat_tag_s head;
  logic            issue, is_start, is_end;

  profiler_tag_fifo #(
    .els_p   (fifo_els_p),
    .width_p (TW)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (req.req_v & done_q),
    .data_i  (req.req_tag),
    .ready_o (fifo_ready),
    .v_o     (fifo_v),
    .data_o  (fifo_data),
    .yumi_i  (issue)
  );

  assign req.req_ready = done_q & fifo_ready;
  assign head     = print_stat_tag_s'(fifo_data);
  assign issue    = fifo_v & (gap_q == '0);
  assign is_start = issue & (head.tag_type == kernel_start);
  assign is_end   = issue & (head.tag_type == kernel_end);
  assign kctr_inc = (&kctr_q) ? kctr_q : kctr_q + 32'd1;

  // Global counter, issue pulse and inter-pulse gap.
  always_comb begin
    done_d = 1'b1;
    gctr_d = done_q ? gctr_q + 32'd1 : '0;
    psv_d  = 1'b0;
    tag_d  = tag_q;
    gap_d  = gap_q;
    if (issue) begin
      psv_d = 1'b1;
      tag_d = head;
      gap_d = GAP_RELOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end
  end

  // Kernel FSM, kernel counter and period strobe.
  always_comb begin
    st_d   = st_q;
    kctr_d = kctr_q;
    pcnt_d = pcnt_q;
    pv_d   = 1'b0;
    unique case (1'b1)
      is_start: begin
        st_d   = KS_ACTIVE;
        kctr_d = '0;
        pcnt_d = '0;
      end
      is_end: begin
        st_d   = KS_IDLE;
        pcnt_d = '0;
        if (st_q == KS_ACTIVE) kctr_d = kctr_inc;
      end
      default: begin
        if (st_q == KS_ACTIVE) begin
          kctr_d = kctr_inc;
          if (pcnt_q == PER_LAST) begin
            pcnt_d = '0;
            pv_d   = 1'b1;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      done_q <= 1'b0;
      gctr_q <= '0;
      psv_q  <= 1'b0;
      tag_q  <= '0;
      gap_q  <= '0;
      st_q   <= KS_IDLE;
      kctr_q <= '0;
      pcnt_q <= '0;
      pv_q   <= 1'b0;
    end else begin
      done_q <= done_d;
      gctr_q <= gctr_d;
      psv_q  <= psv_d;
      tag_q  <= tag_d;
      gap_q  <= gap_d;
      st_q   <= st_d;
      kctr_q <= kctr_d;
      pcnt_q <= pcnt_d;
      pv_q   <= pv_d;
    end
  end

  assign global_ctr_o     = gctr_q;
  assign print_stat_v_o   = psv_q;
  assign print_stat_tag_o = tag_q;
  assign kernel_active_o  = (st_q == KS_ACTIVE);
  assign kernel_ctr_o     = kctr_q;
  assign period_v_o       = pv_q;

endmodule

// File: tb/tb_profiler_trigger_ctrl.sv
// tb_profiler_trigger_ctrl: vector table, directed sequences and
// random traffic against a queue/edge-count reference model.
module tb_profiler_trigger_ctrl;

  localparam int FIFO = 4;
  localparam int GAP  = 4;
  localparam int PER  = 250;

  logic        clk;
  logic        reset_i;
  logic [31:0] gctr, ptag, kctr;
  logic        psv, kact, pv;

  profiler_trigger_ctrl_if rif ();

  profiler_trigger_ctrl #(
    .fifo_els_p (FIFO),
    .min_gap_p  (GAP),
    .period_p   (PER)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .req              (rif),
    .global_ctr_o     (gctr),
    .print_stat_v_o   (psv),
    .print_stat_tag_o (ptag),
    .kernel_active_o  (kact),
    .kernel_ctr_o     (kctr),
    .period_v_o       (pv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk;
  int n_fail;

  // Reference model: edge count since release, tag queue,
  // edge of last issue, kernel start edge and held kernel count.
  int          n;
  logic [31:0] mq [$];
  int          last_iss;
  bit          m_act;
  int          kstart;
  int          hold;
  bit          m_v;
  logic [31:0] m_tag;
  bit          m_pv;
  bit          m_acc;

  int          pul_n [$];
  logic [31:0] pul_t [$];
  int          pv_cnt;

  typedef struct {
    bit          v;
    logic [31:0] tag;
    logic [31:0] e_gctr;
    bit          e_rdy;
    bit          e_psv;
    logic [31:0] e_tag;
    bit          e_act;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)",
               nm, act, exp, n);
    end
  endtask

  function automatic void model_reset();
    n = 0;
    mq.delete();
    last_iss = -1000;
    m_act = 0;
    kstart = 0;
    hold = 0;
    m_v = 0;
    m_tag = '0;
    m_pv = 0;
    m_acc = 0;
  endfunction

  task automatic drive(bit v, logic [31:0] t);
    rif.req_v = v;
    rif.req_tag = t;
  endtask

  task automatic check_outputs();
    bit rdy;
    rdy = (n >= 1) && (mq.size() < FIFO);
    chk("global_ctr", gctr, (n == 0) ? 32'd0 : 32'(n - 1));
    chk("req_ready", {31'd0, rif.req_ready}, {31'd0, rdy});
    chk("print_stat_v", {31'd0, psv}, {31'd0, m_v});
    chk("print_stat_tag", ptag, m_tag);
    chk("kernel_active", {31'd0, kact}, {31'd0, m_act});
    chk("kernel_ctr", kctr, m_act ? 32'(n - kstart) : 32'(hold));
    chk("period_v", {31'd0, pv}, {31'd0, m_pv});
  endtask

  task automatic step();
    bit          rdy;
    bit          iss;
    bit          st;
    logic [31:0] t;
    @(posedge clk);
    n++;
    rdy = (n >= 2) && (mq.size() < FIFO);
    iss = (mq.size() != 0) && ((n - last_iss) >= GAP);
    m_acc = rif.req_v && rdy;
    m_v = 0;
    st = 0;
    if (iss) begin
      t = mq.pop_front();
      m_v = 1;
      m_tag = t;
      last_iss = n;
      if (t[31:30] == 2'b10) begin
        m_act = 1;
        kstart = n;
        st = 1;
      end else if (t[31:30] == 2'b11) begin
        if (m_act) hold = n - kstart;
        m_act = 0;
      end
    end
    if (m_acc) mq.push_back(rif.req_tag);
    m_pv = m_act && !st && (((n - kstart) % PER) == 0);
    #1;
    check_outputs();
    if (psv) begin
      pul_n.push_back(n);
      pul_t.push_back(ptag);
    end
    if (pv) pv_cnt++;
  endtask

  task automatic push_tag(logic [31:0] t, output bit blocked);
    blocked = 0;
    drive(1'b1, t);
    for (int i = 0; i < 50; i++) begin
      if (!rif.req_ready) blocked = 1;
      step();
      if (m_acc) break;
    end
    chk("push_accepted", {31'd0, m_acc}, 32'd1);
    drive(1'b0, '0);
  endtask

  task automatic wait_issue(logic [31:0] t, output int at);
    bit found;
    found = 0;
    at = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (m_v && m_tag == t) begin
        found = 1;
        at = n;
        break;
      end
    end
    chk("issue_seen", {31'd0, found}, 32'd1);
  endtask

  initial begin
    bit          blk;
    bit          any_blk;
    int          s_edge;
    int          t_edge;
    int          x;
    int          r;
    logic [1:0]  ty;

    n_chk = 0;
    n_fail = 0;
    pv_cnt = 0;
    drive(1'b0, '0);
    model_reset();

    tbl[0] = '{0, 32'h0,    32'd0, 1, 0, 32'h0,  0};
    tbl[1] = '{0, 32'h0,    32'd1, 1, 0, 32'h0,  0};
    tbl[2] = '{1, 32'h5,    32'd2, 1, 0, 32'h0,  0};
    tbl[3] = '{0, 32'h0,    32'd3, 1, 1, 32'h5,  0};
    tbl[4] = '{0, 32'h0,    32'd4, 1, 0, 32'h5,  0};
    tbl[5] = '{1, 32'hA1,   32'd5, 1, 0, 32'h5,  0};
    tbl[6] = '{0, 32'h0,    32'd6, 1, 0, 32'h5,  0};
    tbl[7] = '{0, 32'h0,    32'd7, 1, 1, 32'hA1, 0};
    tbl[8] = '{0, 32'h0,    32'd8, 1, 0, 32'hA1, 0};

    reset_i = 1'b1;
    #2 reset_i = 1'b0;
    #2;
    check_outputs();
    #8 reset_i = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].tag);
      step();
      chk("tbl_gctr", gctr, tbl[i].e_gctr);
      chk("tbl_ready", {31'd0, rif.req_ready}, {31'd0, tbl[i].e_rdy});
      chk("tbl_psv", {31'd0, psv}, {31'd0, tbl[i].e_psv});
      chk("tbl_tag", ptag, tbl[i].e_tag);
      chk("tbl_active", {31'd0, kact}, {31'd0, tbl[i].e_act});
    end
    drive(1'b0, '0);

    pul_n.delete();
    pul_t.delete();
    any_blk = 0;
    for (int i = 0; i < 6; i++) begin
      push_tag(32'h0000_0B00 + 32'(i), blk);
      if (blk) any_blk = 1;
    end
    repeat (40) step();
    chk("burst_blocked", {31'd0, any_blk}, 32'd1);
    chk("burst_count", 32'(pul_n.size()), 32'd6);
    for (int i = 0; i < pul_t.size() && i < 6; i++) begin
      chk("burst_order", pul_t[i], 32'h0000_0B00 + 32'(i));
      if (i > 0) chk("burst_gap", 32'(pul_n[i] - pul_n[i-1]), GAP);
    end

    push_tag(32'h8000_0001, blk);
    wait_issue(32'h8000_0001, s_edge);
    chk("start_active", {31'd0, kact}, 32'd1);
    pv_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (n == s_edge + 250) begin
        chk("period_1", {31'd0, pv}, 32'd1);
        chk("kctr_at_p1", kctr, 32'd250);
      end
      if (n == s_edge + 500) chk("period_2", {31'd0, pv}, 32'd1);
    end
    chk("period_count", 32'(pv_cnt), 32'd2);

    push_tag(32'hC000_0000, blk);
    wait_issue(32'hC000_0000, t_edge);
    chk("end_inactive", {31'd0, kact}, 32'd0);
    chk("end_kctr", kctr, 32'(t_edge - s_edge));
    pv_cnt = 0;
    repeat (300) step();
    chk("idle_no_period", 32'(pv_cnt), 32'd0);
    chk("idle_kctr_hold", kctr, 32'(t_edge - s_edge));
    push_tag(32'hC000_0000, blk);
    wait_issue(32'hC000_0000, x);
    chk("end2_inactive", {31'd0, kact}, 32'd0);
    chk("end2_kctr_hold", kctr, 32'(t_edge - s_edge));

    push_tag(32'h8000_0002, blk);
    wait_issue(32'h8000_0002, x);
    push_tag(32'h0000_0C01, blk);
    push_tag(32'h0000_0C02, blk);
    push_tag(32'h0000_0C03, blk);
    chk("pre_reset_q", 32'(mq.size()), 32'd3);
    #2 reset_i = 1'b0;
    #1;
    model_reset();
    chk("rst_gctr", gctr, 32'd0);
    chk("rst_ready", {31'd0, rif.req_ready}, 32'd0);
    chk("rst_psv", {31'd0, psv}, 32'd0);
    chk("rst_active", {31'd0, kact}, 32'd0);
    chk("rst_kctr", kctr, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b1;
    pul_n.delete();
    pul_t.delete();
    repeat (20) step();
    chk("post_rst_pulses", 32'(pul_n.size()), 32'd0);
    chk("post_rst_gctr", gctr, 32'd19);

    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 63));
      if (r == 0) ty = 2'b10;
      else if (r == 1) ty = 2'b11;
      else ty = {1'b0, r[0]};
      drive(1'($urandom_range(0, 1)),
            {ty, 30'($urandom)});
      step();
    end
    drive(1'b0, '0);
    repeat (30) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
